node_link_fifo: RTL and testbench
=================================

NODE_LINK_FIFO -- requirements
Module: node_link_fifo

Interface
REQ-001 SHALL have parameter: WIDTH, 4, nibble width of node data.
REQ-002 SHALL have parameter: DEPTH, 4, entry count (power of two, 2..16).
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_data  input  WIDTH  nibble from upstream node output.
REQ-006 SHALL have port: in_valid  input  1  push request; the upstream node has no backpressure.
REQ-007 SHALL have port: in_ready  output  1  high when not full.
REQ-008 SHALL have port: out_data  output  WIDTH  head entry, feeding a downstream node A/B/C/D input.
REQ-009 SHALL have port: out_valid  output  1  high when not empty.
REQ-010 SHALL have port: out_ready  input  1  downstream pop request.
REQ-011 SHALL have port: count  output  clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port: overflow  output  1  sticky flag for a dropped push.

Function
REQ-013 SHALL push when in_valid and (not full, or full with out_ready this cycle); a pop is in_valid-independent: out_valid and out_ready.
REQ-014 SHALL write in_data at wr_ptr on push, advance wr_ptr modulo DEPTH.
REQ-015 SHALL advance rd_ptr modulo DEPTH on pop; out_data = mem[rd_ptr] combinationally.
REQ-016 SHALL give latency 1: push in cycle N makes out_valid=1 and out_data=pushed value in cycle N+1 when empty before.
REQ-017 SHALL update count by +1 (push only), -1 (pop only), 0 (both or neither).
REQ-018 SHALL, when full and in_valid with out_ready=0, drop in_data, leave mem/pointers/count unchanged, set overflow=1.
REQ-019 SHALL, when full with in_valid and out_ready both 1, perform pop and push in same cycle; count stays DEPTH; overflow unchanged.
REQ-020 SHALL, when empty with in_valid and out_ready both 1, perform push only (no pass-through); count becomes 1.
REQ-021 SHALL ignore out_ready when empty (no pointer/count change).
REQ-022 SHALL keep overflow set until reset.
REQ-023 SHALL derive full as count==DEPTH and empty as count==0; pointers wrap without extra state.
REQ-024 SHALL drive in_ready = !full and out_valid = !empty, both from registered count only.

Reset
REQ-025 SHALL, on clk edge with reset=1, clear wr_ptr, rd_ptr, count, overflow to 0; in_ready=1, out_valid=0 the following cycle.
REQ-026 SHALL give reset priority over simultaneous push/pop; entries in flight are discarded.
REQ-027 SHALL not require clearing mem contents on reset.

Configuration
REQ-028 SHALL use macro NODE_LINK_ZERO_EN.
REQ-029 SHALL, with NODE_LINK_ZERO_EN defined, force out_data=0 whenever out_valid=0 (downstream node sees idle 4'b0000).
REQ-030 SHALL, without NODE_LINK_ZERO_EN, present mem[rd_ptr] unconditionally (stale value visible when empty).

Verification
REQ-031 SHALL test: reset, push 4'h5 one cycle -> next cycle out_valid=1, out_data=5, count=1.
REQ-032 SHALL test: push 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; pops return 1,2,3,4 in order, then out_valid=0.
REQ-033 SHALL test: full, push 4'h9 with out_ready=0 -> overflow=1, count=4, subsequent pops return 1,2,3,4 (9 absent).
REQ-034 SHALL test: full, in_valid=1 data 4'hA with out_ready=1 -> count stays 4, overflow=0, 4'hA emerges after the three older entries.
REQ-035 SHALL test: 10 push/pop cycles through pointer wrap -> data order preserved; with NODE_LINK_ZERO_EN, out_data=0 when empty.
REQ-036 SHALL test: reset asserted with count=3 and overflow=1 -> next cycle count=0, overflow=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/node_link_fifo.sv
// Single-clock FIFO linking one node's nibble output to a downstream node input; NODE_LINK_ZERO_EN zeroes out_data while empty.
// Latency 1 from push to out_valid; a push into a full FIFO without a same-cycle pop is dropped and latched in overflow.
module node_link_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 16) || ((1 << PW) != DEPTH)) begin : g_bad_depth
    $error("node_link_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, empty, push, pop, drop;

  // Status comes only from the registered count so in_ready/out_valid never see same-cycle inputs.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  assign pop  = !empty && out_ready;
  // A full FIFO still accepts when a pop frees the head slot in the same cycle.
  assign push = in_valid && (!full || out_ready);
  assign drop = in_valid && full && !out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left uninitialised; reset only clears the bookkeeping.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef NODE_LINK_ZERO_EN
  assign out_data = empty ? '0 : mem_q[rd_ptr_q];
`else
  assign out_data = mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_node_link_fifo.sv
// Scoreboarded bench for node_link_fifo: directed scenarios followed by random push/pop/reset traffic.
module tb_node_link_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  node_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: occupancy and sticky flag as plain integers, expected data in arrival order.
  logic [WIDTH-1:0] exp_q[$];
  int               mcount;
  bit               movf;
  bit               mon_en;
  int               n_checks;
  int               n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(mcount));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
      chk("overflow", 32'(overflow), 32'(movf));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL underrun: out_valid=1 with no expected entry at %0t", $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
`ifdef NODE_LINK_ZERO_EN
      else begin
        chk("idle_zero", 32'(out_data), 32'd0);
      end
`endif
    end
  end

  // Drive one cycle of inputs; the model advances just after the monitor has sampled.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bit mpush, mpop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    #1;
    mpop  = (mcount != 0) && r;
    mpush = v && ((mcount != DEPTH) || r);
    if (v && (mcount == DEPTH) && !r) movf = 1'b1;
    if (mpop)  mcount--;
    if (mpush) begin
      exp_q.push_back(d);
      mcount++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v, input logic [WIDTH-1:0] d, input logic r);
    reset     = 1'b1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    #1;
    mcount = 0;
    movf   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    mcount    = 0;
    movf      = 1'b0;
    mon_en    = 1'b0;
    n_checks  = 0;
    n_fail    = 0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single push appears the next cycle.
    step(1'b1, 4'h5, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    // Fill, drop a push while full, drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'h9, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);

    // Full with simultaneous push and pop keeps count at DEPTH.
    do_reset(1'b0, 4'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'hA, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1);

    // Empty with push and pop: push only, then wrap the pointers.
    step(1'b1, 4'h7, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i + 3), 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);

    // Reset from count=3 with overflow set, with traffic present on the reset edge.
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i + 8), 1'b0);
    step(1'b0, 4'h0, 1'b1);
    do_reset(1'b1, 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        step(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0 ? 0 : 1));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 4'h0, 1'b1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
